// File: rtl/ps2_key_sequencer_pkg.sv
// Shared PS/2 set-2 scancode constants, FSM encoding and the scancode->hex-nibble lookup.
package ps2_key_sequencer_pkg;

  localparam logic [7:0] SC_EXT  = 8'hE0;
  localparam logic [7:0] SC_BRK  = 8'hF0;
  localparam logic [7:0] SC_BKSP = 8'h66;
  localparam logic [7:0] SC_ESC  = 8'h76;

  // Index i holds the scancode of hex digit i (0..F).
  localparam logic [15:0][7:0] SC_HEX = {
    8'h2B, 8'h24, 8'h23, 8'h21, 8'h32, 8'h1C, 8'h46, 8'h3E,
    8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16, 8'h45
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kbd_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } key_evt_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] nib;
  } hex_lkp_t;

  function automatic hex_lkp_t hex_lookup(input logic [7:0] code);
    hex_lkp_t r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (SC_HEX[i] == code) begin
        r.hit = 1'b1;
        r.nib = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble -> active-low 7-segment pattern (bit6=A .. bit0=G).
// Zero latency, no flow control.
module hex_to_seg7
  import ps2_key_sequencer_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = 7'h01;
      4'h1: seg = 7'h4F;
      4'h2: seg = 7'h12;
      4'h3: seg = 7'h06;
      4'h4: seg = 7'h4C;
      4'h5: seg = 7'h24;
      4'h6: seg = 7'h20;
      4'h7: seg = 7'h0F;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h04;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h60;
      4'hC: seg = 7'h31;
      4'hD: seg = 7'h42;
      4'hE: seg = 7'h30;
      4'hF: seg = 7'h38;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ps2_key_sequencer.sv
// PS/2 set-2 byte stream -> make/break key events and a 4-digit hex display with an entry dot.
// Latency: one cycle from sampled byte to key_valid/display; no backpressure, bytes are never stalled.
module ps2_key_sequencer
  import ps2_key_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYC  = 2_500_000,
  parameter int DOT_HOLD_CYC = 2_500_000,
  parameter bit SUPPRESS_REP = 1'b1
) (
  input  logic       app_clk,
  input  logic       app_arst_n,
  input  logic       enable,
  input  logic       data_ena,
  input  logic [7:0] data_in,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic [6:0] A_TO_G0_out,
  output logic [6:0] A_TO_G1_out,
  output logic [6:0] A_TO_G2_out,
  output logic [6:0] A_TO_G3_out,
  output logic [3:0] DOTS_out
);

  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int DOT_W = $clog2(DOT_HOLD_CYC + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [DOT_W-1:0] DOT_LOAD = DOT_W'(DOT_HOLD_CYC);

  kbd_state_t       state, state_nxt;
  logic [TO_W-1:0]  to_cnt;
  logic             byte_vld, timeout;
  key_evt_t         evt;
  logic             evt_vld, is_make, rep_hit, accept, disp_make;
  logic             held_vld, held_ext;
  logic [7:0]       held_code;
  hex_lkp_t         lkp;
  logic [6:0]       hex_seg;
  logic [6:0]       digit [4];
  logic [DOT_W-1:0] dot_cnt;
  logic             dot_on;

  assign byte_vld = enable & data_ena;
  assign timeout  = (state != ST_IDLE) && !byte_vld && (to_cnt == TO_LAST);

  always_ff @(posedge app_clk or negedge app_arst_n) begin
    if (!app_arst_n) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else if (data_ena) begin
      case (state)
        ST_IDLE: begin
          if (data_in == SC_EXT)      state_nxt = ST_EXT;
          else if (data_in == SC_BRK) state_nxt = ST_BRK;
          else                        state_nxt = ST_IDLE;
        end
        ST_EXT:  state_nxt = (data_in == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_nxt = ST_IDLE;
    end
  end

  always_comb begin
    evt_vld  = 1'b0;
    evt      = '0;
    evt.code = data_in;
    if (byte_vld) begin
      case (state)
        ST_IDLE: evt_vld = (data_in != SC_EXT) && (data_in != SC_BRK);
        ST_EXT: begin
          evt_vld = (data_in != SC_BRK);
          evt.ext = 1'b1;
        end
        ST_BRK: begin
          evt_vld = 1'b1;
          evt.rel = 1'b1;
        end
        ST_EXT_BRK: begin
          evt_vld = 1'b1;
          evt.ext = 1'b1;
          evt.rel = 1'b1;
        end
        default: evt_vld = 1'b0;
      endcase
    end
  end

  // Counter sits at zero whenever the FSM is (or is about to be) idle, or a byte arrives.
  always_ff @(posedge app_clk or negedge app_arst_n) begin
    if (!app_arst_n)                             to_cnt <= '0;
    else if (state_nxt == ST_IDLE || byte_vld)   to_cnt <= '0;
    else                                         to_cnt <= to_cnt + TO_W'(1);
  end

  assign is_make   = evt_vld && !evt.rel;
  assign rep_hit   = held_vld && (held_code == evt.code) && (held_ext == evt.ext);
  assign accept    = evt_vld && !(SUPPRESS_REP && is_make && rep_hit);
  assign disp_make = accept && is_make && !evt.ext;
  assign lkp       = hex_lookup(data_in);

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (lkp.nib),
    .seg    (hex_seg)
  );

  always_ff @(posedge app_clk or negedge app_arst_n) begin
    if (!app_arst_n) begin
      key_valid   <= 1'b0;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_release <= 1'b0;
      held_vld    <= 1'b0;
      held_code   <= 8'h00;
      held_ext    <= 1'b0;
    end else begin
      key_valid <= accept;
      if (accept) begin
        key_code    <= evt.code;
        key_ext     <= evt.ext;
        key_release <= evt.rel;
      end
      if (is_make) begin
        held_vld  <= 1'b1;
        held_code <= evt.code;
        held_ext  <= evt.ext;
      end else if (evt_vld && rep_hit) begin
        held_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge app_clk or negedge app_arst_n) begin
    if (!app_arst_n) begin
      for (int i = 0; i < 4; i++) digit[i] <= SEG_BLANK;
    end else if (disp_make) begin
      if (lkp.hit) begin
        digit[3] <= digit[2];
        digit[2] <= digit[1];
        digit[1] <= digit[0];
        digit[0] <= hex_seg;
      end else if (data_in == SC_BKSP) begin
        digit[0] <= digit[1];
        digit[1] <= digit[2];
        digit[2] <= digit[3];
        digit[3] <= SEG_BLANK;
      end else if (data_in == SC_ESC) begin
        for (int i = 0; i < 4; i++) digit[i] <= SEG_BLANK;
      end
    end
  end

  // dot_on mirrors (dot_cnt != 0) so DOTS_out comes straight from a flop.
  always_ff @(posedge app_clk or negedge app_arst_n) begin
    if (!app_arst_n) begin
      dot_cnt <= '0;
      dot_on  <= 1'b0;
    end else if (disp_make && lkp.hit) begin
      dot_cnt <= DOT_LOAD;
      dot_on  <= 1'b1;
    end else if (dot_cnt != '0) begin
      dot_cnt <= dot_cnt - DOT_W'(1);
      if (dot_cnt == DOT_W'(1)) dot_on <= 1'b0;
    end
  end

  assign A_TO_G0_out = digit[0];
  assign A_TO_G1_out = digit[1];
  assign A_TO_G2_out = digit[2];
  assign A_TO_G3_out = digit[3];
  assign DOTS_out    = {3'b111, ~dot_on};

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Bench for ps2_key_sequencer: two instances (repeat suppression on/off) against an event-level model.
module tb_ps2_key_sequencer;

  localparam int T = 20;
  localparam int H = 12;

  logic       app_clk    = 1'b0;
  logic       app_arst_n = 1'b0;
  logic       enable     = 1'b1;
  logic       data_ena   = 1'b0;
  logic [7:0] data_in    = 8'h00;

  logic       kv   [2];
  logic [7:0] kc   [2];
  logic       ke   [2];
  logic       kr   [2];
  logic [6:0] sg0  [2];
  logic [6:0] sg1  [2];
  logic [6:0] sg2  [2];
  logic [6:0] sg3  [2];
  logic [3:0] dots [2];

  always #5 app_clk = ~app_clk;

  ps2_key_sequencer #(.TIMEOUT_CYC(T), .DOT_HOLD_CYC(H), .SUPPRESS_REP(1'b1)) u_dut_s1 (
    .app_clk(app_clk), .app_arst_n(app_arst_n), .enable(enable), .data_ena(data_ena),
    .data_in(data_in), .key_valid(kv[0]), .key_code(kc[0]), .key_ext(ke[0]),
    .key_release(kr[0]), .A_TO_G0_out(sg0[0]), .A_TO_G1_out(sg1[0]),
    .A_TO_G2_out(sg2[0]), .A_TO_G3_out(sg3[0]), .DOTS_out(dots[0]));

  ps2_key_sequencer #(.TIMEOUT_CYC(T), .DOT_HOLD_CYC(H), .SUPPRESS_REP(1'b0)) u_dut_s0 (
    .app_clk(app_clk), .app_arst_n(app_arst_n), .enable(enable), .data_ena(data_ena),
    .data_in(data_in), .key_valid(kv[1]), .key_code(kc[1]), .key_ext(ke[1]),
    .key_release(kr[1]), .A_TO_G0_out(sg0[1]), .A_TO_G1_out(sg1[1]),
    .A_TO_G2_out(sg2[1]), .A_TO_G3_out(sg3[1]), .DOTS_out(dots[1]));

  logic [7:0] hex_sc  [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                               8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
  logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                               7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  // Model: pending-prefix flags, held key, digits as nibble values (-1 = blank), dot countdown.
  bit         m_pe [2], m_pb [2], m_hv [2], m_he [2];
  bit         m_kv [2], m_ke [2], m_kr [2];
  logic [7:0] m_hc [2], m_kc [2];
  int         m_idle [2], m_dot [2];
  int         m_dig [2][4];

  int n_cmp = 0, n_bad = 0;
  int n_make [2] = '{0, 0};
  int n_brk  [2] = '{0, 0};

  function automatic int hex_idx(input logic [7:0] b);
    for (int i = 0; i < 16; i++) if (hex_sc[i] == b) return i;
    return -1;
  endfunction

  function automatic logic [6:0] dig_seg(input int d);
    return (d < 0) ? 7'h7F : seg_tab[d];
  endfunction

  task automatic model_reset(input int m);
    m_pe[m] = 0; m_pb[m] = 0; m_hv[m] = 0; m_he[m] = 0; m_hc[m] = 8'h00;
    m_kv[m] = 0; m_ke[m] = 0; m_kr[m] = 0; m_kc[m] = 8'h00;
    m_idle[m] = 0; m_dot[m] = 0;
    for (int i = 0; i < 4; i++) m_dig[m][i] = -1;
  endtask

  task automatic model_step(input int m, input bit supp);
    bit         ev, ext, rel, match, hexload;
    int         hx;
    logic [7:0] b;
    ev = 0; hexload = 0; b = data_in;
    m_kv[m] = 0;
    if (!enable) begin
      m_pe[m] = 0; m_pb[m] = 0; m_idle[m] = 0;
    end else if (data_ena) begin
      m_idle[m] = 0;
      if (!m_pe[m] && !m_pb[m] && b == 8'hE0) m_pe[m] = 1;
      else if (!m_pb[m] && b == 8'hF0)        m_pb[m] = 1;
      else                                    ev = 1;
    end else if (m_pe[m] || m_pb[m]) begin
      m_idle[m]++;
      if (m_idle[m] >= T) begin
        m_pe[m] = 0; m_pb[m] = 0; m_idle[m] = 0;
      end
    end
    if (ev) begin
      ext = m_pe[m]; rel = m_pb[m];
      m_pe[m] = 0; m_pb[m] = 0;
      match = m_hv[m] && (m_hc[m] == b) && (m_he[m] == ext);
      if (rel || !(supp && match)) begin
        m_kv[m] = 1; m_kc[m] = b; m_ke[m] = ext; m_kr[m] = rel;
      end
      if (rel) begin
        if (match) m_hv[m] = 0;
      end else if (!(supp && match)) begin
        m_hv[m] = 1; m_hc[m] = b; m_he[m] = ext;
        if (!ext) begin
          hx = hex_idx(b);
          if (hx >= 0) begin
            for (int i = 3; i > 0; i--) m_dig[m][i] = m_dig[m][i-1];
            m_dig[m][0] = hx;
            hexload = 1;
          end else if (b == 8'h66) begin
            for (int i = 0; i < 3; i++) m_dig[m][i] = m_dig[m][i+1];
            m_dig[m][3] = -1;
          end else if (b == 8'h76) begin
            for (int i = 0; i < 4; i++) m_dig[m][i] = -1;
          end
        end
      end
    end
    if (hexload)          m_dot[m] = H;
    else if (m_dot[m] > 0) m_dot[m]--;
  endtask

  always @(posedge app_clk or negedge app_arst_n) begin
    for (int m = 0; m < 2; m++) begin
      if (!app_arst_n) model_reset(m);
      else             model_step(m, (m == 0));
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  always @(posedge app_clk) begin
    #1;
    for (int m = 0; m < 2; m++) begin
      check((m == 0) ? "cycle_s1" : "cycle_s0",
            {21'd0, kv[m], kc[m], ke[m], kr[m], sg3[m], sg2[m], sg1[m], sg0[m], dots[m]},
            {21'd0, m_kv[m], m_kc[m], m_ke[m], m_kr[m],
             dig_seg(m_dig[m][3]), dig_seg(m_dig[m][2]), dig_seg(m_dig[m][1]),
             dig_seg(m_dig[m][0]), (m_dot[m] != 0) ? 4'hE : 4'hF});
      if (kv[m] === 1'b1 && kr[m] === 1'b0) n_make[m]++;
      if (kv[m] === 1'b1 && kr[m] === 1'b1) n_brk[m]++;
    end
  end

  function automatic logic [27:0] disp(input int m);
    return {sg3[m], sg2[m], sg1[m], sg0[m]};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge app_clk);
  endtask

  task automatic drive(input logic [7:0] b);
    data_in = b; data_ena = 1'b1;
    @(negedge app_clk);
    data_ena = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    drive(b);
    idle(3);
  endtask

  int          mk0, bk0, mk1;
  logic [27:0] dsnap;
  logic [7:0]  rb;
  int          g;

  initial begin
    idle(3);
    check("rst_key", {kv[0], kc[0], ke[0], kr[0]}, 64'd0);
    check("rst_disp", disp(0), 28'hFFFFFFF);
    check("rst_dots", dots[0], 4'hF);
    app_arst_n = 1'b1;
    idle(2);

    // Four hex makes fill the display; dot lit then expires.
    mk0 = n_make[0];
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
    check("t1_digits", disp(0), {7'h4F, 7'h12, 7'h06, 7'h4C});
    check("t1_dot_on", dots[0], 4'b1110);
    check("t1_makes", n_make[0] - mk0, 4);
    idle(H);
    check("t1_dot_off", dots[0], 4'hF);

    // Break / extended make / extended break leave the display alone.
    mk0 = n_make[0]; bk0 = n_brk[0]; dsnap = disp(0);
    send(8'hF0); send(8'h16);
    check("t2_brk", {kc[0], ke[0], kr[0]}, {8'h16, 1'b0, 1'b1});
    send(8'hE0); send(8'h75);
    check("t2_ext_make", {kc[0], ke[0], kr[0]}, {8'h75, 1'b1, 1'b0});
    send(8'hE0); send(8'hF0); send(8'h75);
    check("t2_ext_brk", {kc[0], ke[0], kr[0]}, {8'h75, 1'b1, 1'b1});
    check("t2_disp", disp(0), dsnap);
    check("t2_counts", {32'(n_make[0] - mk0), 32'(n_brk[0] - bk0)}, {32'd1, 32'd2});

    // Typematic repeats.
    mk0 = n_make[0]; bk0 = n_brk[0]; mk1 = n_make[1];
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    check("t3_s1_counts", {32'(n_make[0] - mk0), 32'(n_brk[0] - bk0)}, {32'd2, 32'd1});
    check("t3_s1_digits", {sg1[0], sg0[0]}, {7'h08, 7'h08});
    check("t3_s0_makes", n_make[1] - mk1, 4);

    // Prefix timeout, then byte exactly on the terminal cycle.
    drive(8'hE0); idle(T); drive(8'h45); idle(3);
    check("t4_timeout", {kc[0], ke[0], kr[0]}, {8'h45, 1'b0, 1'b0});
    check("t4_d0", sg0[0], 7'h01);
    drive(8'hE0); idle(T - 1); drive(8'h45); idle(3);
    check("t4_terminal", {kc[0], ke[0], kr[0]}, {8'h45, 1'b1, 1'b0});

    // Backspace, escape, mid-sequence reset.
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
    check("t5_1234", disp(0), {7'h4F, 7'h12, 7'h06, 7'h4C});
    send(8'h66);
    check("t5_bksp", disp(0), {7'h7F, 7'h4F, 7'h12, 7'h06});
    send(8'h76);
    check("t5_esc", disp(0), 28'hFFFFFFF);
    drive(8'hE0); idle(2);
    app_arst_n = 1'b0; idle(1); app_arst_n = 1'b1; idle(1);
    mk0 = n_make[0];
    send(8'h16);
    check("t5_rst_make", {kc[0], ke[0], kr[0]}, {8'h16, 1'b0, 1'b0});
    check("t5_rst_cnt", n_make[0] - mk0, 1);

    // enable=0 discards bytes and any pending prefix.
    send(8'hF0); send(8'h16);
    mk0 = n_make[0]; bk0 = n_brk[0]; dsnap = disp(0);
    enable = 1'b0;
    send(8'h16); send(8'h1E);
    check("t6_no_evt", {32'(n_make[0] - mk0), 32'(n_brk[0] - bk0)}, 64'd0);
    check("t6_disp", disp(0), dsnap);
    send(8'hF0);
    enable = 1'b1;
    send(8'h16);
    check("t6_make", {kc[0], ke[0], kr[0]}, {8'h16, 1'b0, 1'b0});
    check("t6_cnt", n_make[0] - mk0, 1);

    // Randomized traffic, checked every cycle against the model.
    for (int it = 0; it < 2000; it++) begin
      case ($urandom_range(0, 9))
        0:       rb = 8'hE0;
        1:       rb = 8'hF0;
        7:       rb = ($urandom_range(0, 1) != 0) ? 8'h66 : 8'h76;
        8:       rb = 8'($urandom);
        9:       rb = hex_sc[$urandom_range(0, 3)];
        default: rb = hex_sc[$urandom_range(0, 15)];
      endcase
      enable = ($urandom_range(0, 15) != 0);
      drive(rb);
      g = $urandom_range(0, 19);
      if (g < 17) idle(g % 3);
      else        idle($urandom_range(T - 2, T + 1));
      if ($urandom_range(0, 299) == 0) begin
        app_arst_n = 1'b0; idle(1); app_arst_n = 1'b1;
      end
    end
    enable = 1'b1;
    idle(H + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
